// File: rtl/reg_writeback_pkg.sv
// Shared CPU definitions: load size codes and default datapath widths, reused
// by decode, operand generation and writeback.
package reg_writeback_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    // 2'b11 is reserved and behaves like a word load
    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10,
        LD_R = 2'b11
    } ld_size_e;

endpackage

// File: rtl/reg_writeback_load_extend.sv
// Load data extraction: picks the byte/half/word lane addressed by the load
// offset and sign- or zero-extends it to the datapath width.
module reg_writeback_load_extend
    import reg_writeback_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    size,
    input  logic          sign,
    input  logic [1:0]    off,
    input  logic [DW-1:0] word,
    output logic [DW-1:0] data,
    output logic          misalign
);

    function automatic logic [DW-1:0] ext8(input logic [7:0] v, input logic s);
        ext8 = {{(DW-8){s & v[7]}}, v};
    endfunction

    function automatic logic [DW-1:0] ext16(input logic [15:0] v, input logic s);
        ext16 = {{(DW-16){s & v[15]}}, v};
    endfunction

    logic [7:0]  byte_f;
    logic [15:0] half_f;

    always_comb begin
        byte_f = word[{off, 3'b000} +: 8];
        // Half loads use only off[1]; an odd offset is flagged, not corrected
        half_f = word[{off[1], 4'b0000} +: 16];
        case (size)
            LD_B:    data = ext8(byte_f, sign);
            LD_H:    data = ext16(half_f, sign);
            default: data = word;
        endcase
        misalign = (size == LD_H) && off[0];
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: retires ALU results in one cycle, parks on loads until memory
// returns data, and drives the register-file write port plus a forwarding view.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int R0_ZERO = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_waddr,
    input  logic [DW-1:0] ex_wdata,
    input  logic          ex_is_load,
    input  logic [1:0]    ex_ld_size,
    input  logic          ex_ld_sign,
    input  logic [1:0]    ex_ld_off,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          fwd_valid,
    output logic          ld_pend,
    output logic [AW-1:0] ld_pend_addr,
    output logic          ld_misalign
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_e;

    wb_state_e     state;
    logic          ld_we_p0;
    logic [AW-1:0] ld_waddr_p0;
    logic [1:0]    ld_size_p0;
    logic          ld_sign_p0;
    logic [1:0]    ld_off_p0;
    logic [DW-1:0] ld_data;
    logic          ld_mis;

    function automatic logic r0_blocked(input logic [AW-1:0] a);
        return (R0_ZERO != 0) && (a == '0);
    endfunction

    reg_writeback_load_extend #(
        .DW(DW)
    ) u_load_extend (
        .size    (ld_size_p0),
        .sign    (ld_sign_p0),
        .off     (ld_off_p0),
        .word    (mem_rdata),
        .data    (ld_data),
        .misalign(ld_mis)
    );

    assign ex_ready  = (state == IDLE);
    assign fwd_valid = rf_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            ld_pend      <= 1'b0;
            ld_pend_addr <= '0;
            ld_misalign  <= 1'b0;
            ld_we_p0     <= 1'b0;
        end else begin
            rf_we       <= 1'b0;
            ld_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (ex_is_load) begin
                            ld_we_p0     <= ex_we;
                            ld_waddr_p0  <= ex_waddr;
                            ld_size_p0   <= ex_ld_size;
                            ld_sign_p0   <= ex_ld_sign;
                            ld_off_p0    <= ex_ld_off;
                            ld_pend      <= 1'b1;
                            ld_pend_addr <= ex_waddr;
                            state        <= WAIT_MEM;
                        end else begin
                            rf_we    <= ex_we && !r0_blocked(ex_waddr);
                            rf_waddr <= ex_waddr;
                            rf_wdata <= ex_wdata;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        rf_we       <= ld_we_p0 && !r0_blocked(ld_waddr_p0);
                        rf_waddr    <= ld_waddr_p0;
                        rf_wdata    <= ld_data;
                        ld_misalign <= ld_mis;
                        ld_pend     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: one instance with R0 suppression, one without.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_we, ex_is_load, ex_ld_sign, mem_rvalid;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata, mem_rdata;
    logic [1:0]  ex_ld_size, ex_ld_off;

    logic        ex_ready, rf_we, fwd_valid, ld_pend, ld_misalign;
    logic [4:0]  rf_waddr, ld_pend_addr;
    logic [31:0] rf_wdata;

    logic        nz_ex_ready, nz_rf_we, nz_fwd_valid, nz_ld_pend, nz_ld_misalign;
    logic [4:0]  nz_rf_waddr, nz_ld_pend_addr;
    logic [31:0] nz_rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_writeback #(.DW(32), .AW(5), .R0_ZERO(1)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we),
        .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .ex_ld_size(ex_ld_size), .ex_ld_sign(ex_ld_sign), .ex_ld_off(ex_ld_off),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .ld_pend(ld_pend), .ld_pend_addr(ld_pend_addr),
        .ld_misalign(ld_misalign)
    );

    reg_writeback #(.DW(32), .AW(5), .R0_ZERO(0)) dut_nz (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(nz_ex_ready), .ex_we(ex_we),
        .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .ex_ld_size(ex_ld_size), .ex_ld_sign(ex_ld_sign), .ex_ld_off(ex_ld_off),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(nz_rf_we), .rf_waddr(nz_rf_waddr), .rf_wdata(nz_rf_wdata),
        .fwd_valid(nz_fwd_valid), .ld_pend(nz_ld_pend), .ld_pend_addr(nz_ld_pend_addr),
        .ld_misalign(nz_ld_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_we = 1'b1; ex_waddr = a; ex_wdata = d;
    endtask

    task automatic load(input logic we, input logic [4:0] a, input logic [1:0] sz,
                        input logic sg, input logic [1:0] off);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_we = we; ex_waddr = a;
        ex_ld_size = sz; ex_ld_sign = sg; ex_ld_off = off; ex_wdata = 32'hBAD0_BAD0;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_we = 1'b0; ex_waddr = 5'd0;
        ex_wdata = 32'd0; ex_ld_size = 2'd0; ex_ld_sign = 1'b0; ex_ld_off = 2'd0;
    endtask

    initial begin
        rst = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        idle_in();
        tick(); tick();
        rst = 1'b0;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_ld_pend", ld_pend, 0);
        chk("rst_ld_pend_addr", ld_pend_addr, 0);
        chk("rst_ld_misalign", ld_misalign, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_nz_state", {nz_ex_ready, nz_rf_we, nz_fwd_valid, nz_ld_pend, nz_ld_misalign}, 5'b10000);
        chk("rst_nz_addr", {nz_rf_waddr, nz_ld_pend_addr}, 0);
        chk("rst_nz_wdata", nz_rf_wdata, 0);

        // back-to-back ALU results
        alu(5'd1, 32'h11);
        chk("alu1_ready", ex_ready, 1);
        tick();
        chk("alu1_we", rf_we, 1); chk("alu1_fwd", fwd_valid, 1);
        chk("alu1_addr", rf_waddr, 1); chk("alu1_data", rf_wdata, 32'h11);
        alu(5'd2, 32'h22);
        chk("alu2_ready", ex_ready, 1);
        tick();
        chk("alu2_we", rf_we, 1); chk("alu2_addr", rf_waddr, 2); chk("alu2_data", rf_wdata, 32'h22);
        alu(5'd3, 32'h33);
        chk("alu3_ready", ex_ready, 1);
        tick();
        chk("alu3_we", rf_we, 1); chk("alu3_addr", rf_waddr, 3); chk("alu3_data", rf_wdata, 32'h33);
        idle_in();
        tick();
        chk("alu_end_we", rf_we, 0);

        // signed byte load r4, off 3, data two cycles later
        load(1'b1, 5'd4, 2'b00, 1'b1, 2'd3);
        tick();
        alu(5'd9, 32'h99);
        chk("lb_wait1_ready", ex_ready, 0);
        chk("lb_wait1_pend", ld_pend, 1);
        chk("lb_wait1_paddr", ld_pend_addr, 4);
        chk("lb_wait1_we", rf_we, 0);
        tick();
        idle_in();
        chk("lb_wait2_ready", ex_ready, 0);
        chk("lb_wait2_pend", ld_pend, 1);
        chk("lb_wait2_we", rf_we, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
        tick();
        mem_rvalid = 1'b0;
        chk("lb_we", rf_we, 1); chk("lb_ready", ex_ready, 1);
        chk("lb_addr", rf_waddr, 4); chk("lb_data", rf_wdata, 32'hFFFF_FF80);
        chk("lb_pend", ld_pend, 0); chk("lb_mis", ld_misalign, 0);
        tick();
        chk("lb_after_we", rf_we, 0);

        // unsigned half, upper lane
        load(1'b1, 5'd5, 2'b01, 1'b0, 2'd2);
        tick();
        idle_in();
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_7FFF;
        tick();
        mem_rvalid = 1'b0;
        chk("lhu_we", rf_we, 1); chk("lhu_addr", rf_waddr, 5);
        chk("lhu_data", rf_wdata, 32'h0000_8001); chk("lhu_mis", ld_misalign, 0);

        // signed half, odd offset -> lower lane, misalign pulse
        load(1'b1, 5'd6, 2'b01, 1'b1, 2'd1);
        tick();
        idle_in();
        chk("lhm_pend", ld_pend, 1);
        chk("lhm_mis_wait", ld_misalign, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_7FFF;
        tick();
        mem_rvalid = 1'b0;
        chk("lhm_we", rf_we, 1); chk("lhm_addr", rf_waddr, 6);
        chk("lhm_data", rf_wdata, 32'h0000_7FFF); chk("lhm_mis", ld_misalign, 1);
        tick();
        chk("lhm_mis_clr", ld_misalign, 0);

        // r0 writes: suppressed only with R0_ZERO=1
        alu(5'd0, 32'hDEAD_BEEF);
        tick();
        idle_in();
        chk("r0_alu_we", rf_we, 0);
        chk("r0_alu_nz_we", nz_rf_we, 1);
        chk("r0_alu_nz_data", nz_rf_wdata, 32'hDEAD_BEEF);
        load(1'b1, 5'd0, 2'b10, 1'b0, 2'd1);
        tick();
        idle_in();
        chk("r0_ld_pend", ld_pend, 1); chk("r0_ld_paddr", ld_pend_addr, 0);
        chk("r0_ld_wait_we", rf_we, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("r0_ld_we", rf_we, 0);
        chk("r0_ld_nz_we", nz_rf_we, 1);
        chk("r0_ld_nz_data", nz_rf_wdata, 32'hCAFE_F00D);

        // reset during WAIT_MEM drops the load
        load(1'b1, 5'd7, 2'b10, 1'b0, 2'd0);
        tick();
        idle_in();
        chk("rml_pend", ld_pend, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        chk("rml_we", rf_we, 0); chk("rml_pend_clr", ld_pend, 0);
        chk("rml_ready", ex_ready, 1); chk("rml_data", rf_wdata, 0);

        // stray rvalid in IDLE, then a normal ALU write
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_we", rf_we, 0); chk("stray_data", rf_wdata, 0);
        alu(5'd8, 32'h88);
        tick();
        idle_in();
        chk("post_stray_we", rf_we, 1); chk("post_stray_addr", rf_waddr, 8);
        chk("post_stray_data", rf_wdata, 32'h88);

        // load with we=0 still waits but writes nothing
        load(1'b0, 5'd10, 2'b10, 1'b0, 2'd0);
        tick();
        idle_in();
        chk("nowe_ready", ex_ready, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        mem_rvalid = 1'b0;
        chk("nowe_we", rf_we, 0); chk("nowe_pend", ld_pend, 0); chk("nowe_ready2", ex_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
